gb_cart_mbc1: RTL and testbench

GB_CART_MBC1 -- requirements
Module: gb_cart_mbc1

---
 rtl/gb_cart_pkg.sv | 16 +
 rtl/gb_cart_mbc1.sv | 59 +++++
 tb/tb_gb_cart_mbc1.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg: MBC1 register-window map, RAM-enable key and bank reset value
package gb_cart_pkg;
   typedef logic [2:0] region_t;
   localparam logic [15:0] RAM_EN_BASE   = 16'h0000;
   localparam logic [15:0] BANK1_BASE    = 16'h2000;
   localparam logic [15:0] BANK2_BASE    = 16'h4000;
   localparam logic [15:0] MODE_BASE     = 16'h6000;
   localparam logic [15:0] CART_RAM_BASE = 16'hA000;
   localparam logic [3:0]  RAM_KEY       = 4'hA;
   localparam logic [4:0]  BANK1_RST     = 5'd1;
   localparam region_t REG_RAM_EN   = RAM_EN_BASE[15:13];
   localparam region_t REG_BANK1    = BANK1_BASE[15:13];
   localparam region_t REG_BANK2    = BANK2_BASE[15:13];
   localparam region_t REG_MODE     = MODE_BASE[15:13];
   localparam region_t REG_CART_RAM = CART_RAM_BASE[15:13];
endpackage

// File: rtl/gb_cart_mbc1.sv
// gb_cart_mbc1: MBC1 bank controller with registered ROM/RAM address mapping
module gb_cart_mbc1
   import gb_cart_pkg::*;
#(
   parameter int ROM_ADDR_W = 16,
   parameter int RAM_ADDR_W = 13
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ready,
   input  logic [15:0]           cpu_addr,
   input  logic [7:0]            cpu_din,
   input  logic                  cpu_wr,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   output logic                  rom_cs,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic                  ram_cs,
   output logic                  ram_we
);
   logic ram_en, mode, wr_q, wr_evt, in_ram;
   logic [4:0] bank1;
   logic [1:0] bank2, ram_bank;
   logic [6:0] rom_bank;
   region_t region;
   logic unused_din;
   assign unused_din = ^cpu_din[7:5];
   always_comb begin
      region   = cpu_addr[15:13];
      wr_evt   = ready & cpu_wr & ~wr_q;
      in_ram   = region == REG_CART_RAM;
      rom_bank = cpu_addr[14] ? {bank2, bank1} : (mode ? {bank2, 5'd0} : 7'd0);
      ram_bank = mode ? bank2 : 2'd0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q     <= 1'b1;
         ram_en   <= 1'b0;
         bank1    <= BANK1_RST;
         bank2    <= 2'd0;
         mode     <= 1'b0;
         rom_addr <= '0;
         rom_cs   <= 1'b0;
         ram_addr <= '0;
         ram_cs   <= 1'b0;
         ram_we   <= 1'b0;
      end else begin
         wr_q <= cpu_wr;
         if (wr_evt && region == REG_RAM_EN) ram_en <= cpu_din[3:0] == RAM_KEY;
         if (wr_evt && region == REG_BANK1) bank1 <= (cpu_din[4:0] == 5'd0) ? BANK1_RST : cpu_din[4:0];
         if (wr_evt && region == REG_BANK2) bank2 <= cpu_din[1:0];
         if (wr_evt && region == REG_MODE) mode <= cpu_din[0];
         rom_addr <= ROM_ADDR_W'({rom_bank, cpu_addr[13:0]});
         rom_cs   <= ~cpu_addr[15];
         ram_addr <= RAM_ADDR_W'({ram_bank, cpu_addr[12:0]});
         ram_cs   <= in_ram & ram_en;
         ram_we   <= wr_evt & in_ram & ram_en;
      end
   end
endmodule

// File: tb/tb_gb_cart_mbc1.sv
// tb_gb_cart_mbc1: scoreboard bench; a second wide instance exposes bank2/mode bits
module tb_gb_cart_mbc1;
   typedef logic [31:0] obs_t;
   typedef logic [35:0] wobs_t;
   typedef struct packed {
      logic rst, rdy, w;
      logic [15:0] a;
      logic [7:0] d;
      obs_t x, m;
      wobs_t wx, wm;
   } step_t;
   typedef struct packed {obs_t x, m; wobs_t wx, wm;} exp_t;

   localparam obs_t ROMM = 32'hFFFF_8003;
   localparam obs_t RAMM = 32'h0000_FFFF;
   localparam obs_t CSM  = 32'h0000_8003;
   localparam obs_t ALLM = '1;
   localparam wobs_t WALL  = '1;
   localparam wobs_t WROMM = {21'h1FFFFF, 15'h0};
   localparam wobs_t WRAMM = {21'h0, 15'h7FFF};

   logic clk, reset, ready, cpu_wr;
   logic [15:0] cpu_addr;
   logic [7:0] cpu_din;
   logic [15:0] rom_addr;
   logic [12:0] ram_addr;
   logic rom_cs, ram_cs, ram_we;
   logic [20:0] rom_addr_w;
   logic [14:0] ram_addr_w;
   logic rom_cs_w, ram_cs_w, ram_we_w;
   obs_t obs;
   wobs_t wobs;
   exp_t sb[$];
   int passed = 0, total = 0;

   gb_cart_mbc1 dut (
      .clk(clk), .reset(reset), .ready(ready), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_wr(cpu_wr), .rom_addr(rom_addr), .rom_cs(rom_cs), .ram_addr(ram_addr),
      .ram_cs(ram_cs), .ram_we(ram_we)
   );
   gb_cart_mbc1 #(.ROM_ADDR_W(21), .RAM_ADDR_W(15)) dut_w (
      .clk(clk), .reset(reset), .ready(ready), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_wr(cpu_wr), .rom_addr(rom_addr_w), .rom_cs(rom_cs_w), .ram_addr(ram_addr_w),
      .ram_cs(ram_cs_w), .ram_we(ram_we_w)
   );

   assign obs  = {rom_addr, rom_cs, ram_addr, ram_cs, ram_we};
   assign wobs = {rom_addr_w, ram_addr_w};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t ro(input logic [15:0] r);
      return {r, 1'b1, 13'h0, 2'b00};
   endfunction
   function automatic obs_t ra(input logic [12:0] r, input logic cs, input logic we);
      return {16'h0, 1'b0, r, cs, we};
   endfunction
   function automatic wobs_t wro(input logic [20:0] r);
      return {r, 15'h0};
   endfunction
   function automatic wobs_t wra(input logic [14:0] r);
      return {21'h0, r};
   endfunction
   function automatic step_t f(input logic rst, input logic rdy, input logic w, input logic [15:0] a,
                               input logic [7:0] d, input obs_t x, input obs_t m, input wobs_t wx, input wobs_t wm);
      return '{rst, rdy, w, a, d, x, m, wx, wm};
   endfunction
   function automatic step_t n(input logic w, input logic [15:0] a, input logic [7:0] d, input obs_t x, input obs_t m);
      return f(1'b0, 1'b1, w, a, d, x, m, '0, '0);
   endfunction
   function automatic step_t wn(input logic w, input logic [15:0] a, input logic [7:0] d, input obs_t x,
                                input obs_t m, input wobs_t wx, input wobs_t wm);
      return f(1'b0, 1'b1, w, a, d, x, m, wx, wm);
   endfunction

   task automatic drive(input step_t s);
      reset = s.rst;
      ready = s.rdy;
      cpu_wr = s.w;
      cpu_addr = s.a;
      cpu_din = s.d;
      sb.push_back('{s.x, s.m, s.wx, s.wm});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      step_t t[5];
      exp_t e;
      t = '{f(1'b1, 1'b0, 1'b0, 16'h4123, 8'h00, '0, ALLM, '0, WALL),
            f(1'b1, 1'b1, 1'b1, 16'h2000, 8'h03, '0, ALLM, '0, WALL),
            n(1'b0, 16'h4123, 8'h00, ro(16'h4123), ROMM),
            n(1'b0, 16'h0000, 8'h00, ro(16'h0000), ROMM),
            n(1'b0, 16'h3FFF, 8'h00, ro(16'h3FFF), ROMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL reset[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_bank_zero();
      step_t t[8];
      exp_t e;
      t = '{n(1'b1, 16'h2000, 8'h02, ro(16'h2000), ROMM), n(1'b0, 16'h4000, 8'h00, ro(16'h8000), ROMM),
            n(1'b1, 16'h2000, 8'h00, ro(16'h2000), ROMM), n(1'b0, 16'h4000, 8'h00, ro(16'h4000), ROMM),
            n(1'b1, 16'h2000, 8'h02, ro(16'h2000), ROMM), n(1'b0, 16'h4000, 8'h00, ro(16'h8000), ROMM),
            n(1'b1, 16'h2000, 8'h20, ro(16'h2000), ROMM), n(1'b0, 16'h4000, 8'h00, ro(16'h4000), ROMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL bank_zero[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_wrap();
      step_t t[7];
      exp_t e;
      t = '{n(1'b1, 16'h2100, 8'h03, ro(16'h2100), ROMM), n(1'b0, 16'h7FFF, 8'h00, ro(16'hFFFF), ROMM),
            n(1'b1, 16'h2100, 8'h07, ro(16'h2100), ROMM), n(1'b0, 16'h7FFF, 8'h00, ro(16'hFFFF), ROMM),
            n(1'b0, 16'h4000, 8'h00, ro(16'hC000), ROMM), n(1'b1, 16'h3FFF, 8'h04, ro(16'h3FFF), ROMM),
            n(1'b0, 16'h5555, 8'h00, ro(16'h1555), ROMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL wrap[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_ram();
      step_t t[13];
      exp_t e;
      t = '{n(1'b1, 16'hA000, 8'h55, ra(13'h0000, 1'b0, 1'b0), RAMM),
            n(1'b0, 16'hA000, 8'h00, ra(13'h0000, 1'b0, 1'b0), RAMM),
            n(1'b1, 16'h0000, 8'h0A, ro(16'h0000), ROMM),
            n(1'b0, 16'hA010, 8'h00, ra(13'h0010, 1'b1, 1'b0), RAMM),
            n(1'b1, 16'hA010, 8'h77, ra(13'h0010, 1'b1, 1'b1), RAMM),
            n(1'b1, 16'hA010, 8'h77, ra(13'h0010, 1'b1, 1'b0), RAMM),
            n(1'b0, 16'hBFFF, 8'h00, ra(13'h1FFF, 1'b1, 1'b0), RAMM),
            n(1'b1, 16'h1FFF, 8'h1B, ro(16'h1FFF), ROMM),
            n(1'b0, 16'hA010, 8'h00, ra(13'h0010, 1'b0, 1'b0), RAMM),
            n(1'b1, 16'hA010, 8'h11, ra(13'h0010, 1'b0, 1'b0), RAMM),
            n(1'b0, 16'hA010, 8'h00, ra(13'h0010, 1'b0, 1'b0), RAMM),
            n(1'b1, 16'h1000, 8'h3A, ro(16'h1000), ROMM),
            n(1'b0, 16'hA000, 8'h00, ra(13'h0000, 1'b1, 1'b0), RAMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL ram[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_ignored_regions();
      step_t t[9];
      exp_t e;
      t = '{n(1'b1, 16'h8000, 8'h03, ra(13'h0, 1'b0, 1'b0), CSM),
            n(1'b0, 16'h9FFF, 8'h00, ra(13'h0, 1'b0, 1'b0), CSM),
            n(1'b1, 16'hA000, 8'h03, ra(13'h0, 1'b1, 1'b1), RAMM),
            n(1'b0, 16'hC000, 8'h00, ra(13'h0, 1'b0, 1'b0), CSM),
            n(1'b1, 16'hC000, 8'h03, ra(13'h0, 1'b0, 1'b0), CSM),
            n(1'b0, 16'hE000, 8'h00, ra(13'h0, 1'b0, 1'b0), CSM),
            n(1'b1, 16'hFFFF, 8'h03, ra(13'h0, 1'b0, 1'b0), CSM),
            n(1'b0, 16'h4000, 8'h00, ro(16'h0000), ROMM),
            n(1'b0, 16'hA000, 8'h00, ra(13'h0, 1'b1, 1'b0), RAMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL ignored[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_held_write();
      step_t t[6];
      exp_t e;
      t = '{n(1'b1, 16'h2000, 8'h02, ro(16'h2000), ROMM), n(1'b1, 16'h2000, 8'h03, ro(16'h2000), ROMM),
            n(1'b1, 16'h2000, 8'h03, ro(16'h2000), ROMM), n(1'b1, 16'h2000, 8'h03, ro(16'h2000), ROMM),
            n(1'b1, 16'h2000, 8'h03, ro(16'h2000), ROMM), n(1'b0, 16'h4000, 8'h00, ro(16'h8000), ROMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL held_write[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_ready();
      step_t t[8];
      exp_t e;
      t = '{f(1'b0, 1'b0, 1'b0, 16'h2000, 8'h01, ro(16'h2000), ROMM, '0, '0),
            f(1'b0, 1'b0, 1'b1, 16'h2000, 8'h01, ro(16'h2000), ROMM, '0, '0),
            f(1'b0, 1'b0, 1'b1, 16'h2000, 8'h01, ro(16'h2000), ROMM, '0, '0),
            f(1'b0, 1'b1, 1'b1, 16'h2000, 8'h01, ro(16'h2000), ROMM, '0, '0),
            f(1'b0, 1'b1, 1'b1, 16'h4000, 8'h01, ro(16'h8000), ROMM, '0, '0),
            n(1'b0, 16'h4000, 8'h00, ro(16'h8000), ROMM),
            n(1'b1, 16'h2000, 8'h01, ro(16'h2000), ROMM),
            n(1'b0, 16'h4000, 8'h00, ro(16'h4000), ROMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL ready[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_write();
      step_t t[9];
      exp_t e;
      t = '{n(1'b1, 16'h2000, 8'h03, ro(16'h2000), ROMM),
            n(1'b1, 16'h4000, 8'h03, ro(16'hC000), ROMM),
            f(1'b1, 1'b1, 1'b1, 16'h6000, 8'h01, '0, ALLM, '0, WALL),
            n(1'b1, 16'h4000, 8'h01, ro(16'h4000), ROMM),
            n(1'b1, 16'h2000, 8'h03, ro(16'h2000), ROMM),
            n(1'b0, 16'h4000, 8'h00, ro(16'h4000), ROMM),
            n(1'b1, 16'h2000, 8'h03, ro(16'h2000), ROMM),
            n(1'b0, 16'h4000, 8'h00, ro(16'hC000), ROMM),
            n(1'b0, 16'hA000, 8'h00, ra(13'h0, 1'b0, 1'b0), RAMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL reset_mid[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   task automatic test_mode();
      step_t t[14];
      exp_t e;
      t = '{wn(1'b1, 16'h6000, 8'h01, ro(16'hE000), ROMM, wro(21'h00E000), WROMM),
            f(1'b1, 1'b1, 1'b1, 16'h6000, 8'h01, '0, ALLM, '0, WALL),
            wn(1'b1, 16'h6000, 8'h01, ro(16'h6000), ROMM, wro(21'h006000), WROMM),
            wn(1'b0, 16'h4000, 8'h00, ro(16'h4000), ROMM, wro(21'h004000), WROMM),
            wn(1'b1, 16'h4000, 8'h02, ro(16'h4000), ROMM, wro(21'h004000), WROMM),
            wn(1'b0, 16'h0123, 8'h00, ro(16'h0123), ROMM, wro(21'h000123), WROMM),
            wn(1'b0, 16'h4123, 8'h00, ro(16'h4123), ROMM, wro(21'h104123), WROMM),
            wn(1'b1, 16'h6000, 8'h01, ro(16'h6000), ROMM, wro(21'h106000), WROMM),
            wn(1'b0, 16'h0123, 8'h00, ro(16'h0123), ROMM, wro(21'h100123), WROMM),
            wn(1'b1, 16'h0000, 8'h0A, ro(16'h0000), ROMM, wro(21'h100000), WROMM),
            wn(1'b0, 16'hA010, 8'h00, ra(13'h0010, 1'b1, 1'b0), RAMM, wra(15'h4010), WRAMM),
            wn(1'b1, 16'h6000, 8'h00, ro(16'h6000), ROMM, wro(21'h106000), WROMM),
            wn(1'b0, 16'hA010, 8'h00, ra(13'h0010, 1'b1, 1'b0), RAMM, wra(15'h0010), WRAMM),
            wn(1'b0, 16'h0123, 8'h00, ro(16'h0123), ROMM, wro(21'h000123), WROMM)};
      foreach (t[i]) begin
         drive(t[i]);
         e = sb.pop_front();
         total++;
         if ((obs & e.m) !== (e.x & e.m) || (wobs & e.wm) !== (e.wx & e.wm))
            $display("FAIL mode[%0d]: got %h/%h want %h/%h", i, obs & e.m, wobs & e.wm, e.x & e.m, e.wx & e.wm);
         else passed++;
      end
   endtask

   initial begin
      reset = 1'b1;
      ready = 1'b0;
      cpu_wr = 1'b0;
      cpu_addr = 16'h0;
      cpu_din = 8'h0;
      @(negedge clk);
      test_reset();
      test_bank_zero();
      test_wrap();
      test_ram();
      test_ignored_regions();
      test_held_write();
      test_ready();
      test_reset_mid_write();
      test_mode();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
